// File: rtl/block_fifo.sv
// First-word-fall-through FIFO: block RAM store plus one output register.
// Capacity is DEPTH+1 words; valid/ready on both sides, sync flush.
module block_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_BITS   = 4,
   parameter int ALMOST_FULL = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic [ADDR_BITS:0]    count,
   output logic                  almost_full
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS:0] RAM_FULL = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS:0] AF_LEVEL = (ADDR_BITS + 1)'(ALMOST_FULL);
   localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS + 1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_BITS-1:0]  wr_ptr;
   logic [ADDR_BITS-1:0]  rd_ptr;
   logic [ADDR_BITS:0]    ram_count;
   logic [DATA_WIDTH-1:0] out_reg;
   logic                  wr;
   logic                  pop;
   logic                  load;

   assign in_ready = rst_n & ~flush & (ram_count != RAM_FULL);
   assign wr       = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   // ram_count is registered, so a load never sees a same-edge write
   assign load     = ~flush & (ram_count != '0) & (~out_valid | out_ready);

   assign out         = out_reg;
   assign count       = ram_count + {{ADDR_BITS{1'b0}}, out_valid};
   assign almost_full = (count >= AF_LEVEL);

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
      end else if (load) begin
         out_reg <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         out_valid <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (load) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({wr, load})
            2'b10:   ram_count <= ram_count + CNT_ONE;
            2'b01:   ram_count <= ram_count - CNT_ONE;
            default: ram_count <= ram_count;
         endcase
         if (load) begin
            out_valid <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_block_fifo.sv
// Scoreboard bench for block_fifo: accepted words queue up as expectations,
// a negedge monitor checks every pop against them.
module tb_block_fifo;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] din;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic [4:0] count;
   logic       almost_full;

   int checks = 0;
   int errors = 0;
   int n_pop  = 0;
   logic [7:0] sb[$];

   block_fifo #(
      .DATA_WIDTH (8),
      .ADDR_BITS  (4),
      .ALMOST_FULL(12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in         (din),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (dout),
      .count      (count),
      .almost_full(almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected words enter the scoreboard at the handshake
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) sb.push_back(din);
   end

   always @(negedge clk) begin
      logic [7:0] exp;
      if (rst_n && !flush && out_valid && out_ready) begin
         checks++;
         n_pop++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_empty: out=%h with no word expected", dout);
         end else begin
            exp = sb.pop_front();
            if (dout !== exp) begin
               errors++;
               $display("FAIL pop_data: out=%h expected %h", dout, exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((count != 0 || sb.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, 32'(count), 32'd0);
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int exp_cnt;
      int sent;
      int cyc;
      int pops0;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; din = 8'h00;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_out", 32'(dout), 32'd0);

      // three words with the consumer always ready
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1; din = 8'h11; out_ready = 1'b1;
      tick();
      chk("t1_latency_ov", 32'(out_valid), 32'd0);
      din = 8'h22;
      tick();
      chk("t1_ov", 32'(out_valid), 32'd1);
      chk("t1_out0", 32'(dout), 32'h11);
      din = 8'h33;
      tick();
      chk("t1_out1", 32'(dout), 32'h22);
      in_valid = 1'b0;
      tick();
      chk("t1_out2", 32'(dout), 32'h33);
      tick();
      chk("t1_count", 32'(count), 32'd0);
      chk("t1_ov_end", 32'(out_valid), 32'd0);

      // fill with consumer stalled
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; din = 8'(8'h40 + i);
         #1;
         if (in_ready) acc++;
         tick();
         exp_cnt = (i + 1 > 17) ? 17 : i + 1;
         chk("fill_count", 32'(count), 32'(exp_cnt));
         chk("fill_af", 32'(almost_full), 32'(exp_cnt >= 12));
         chk("fill_in_ready", 32'(in_ready), 32'(exp_cnt < 17));
         if (i >= 1) chk("fill_out_stable", 32'(dout), 32'h40);
      end
      chk("fill_accepted", 32'(acc), 32'd17);

      // one pop from full: in_ready stays low that cycle
      din = 8'h60; out_ready = 1'b1;
      #1;
      chk("full_pop_in_ready", 32'(in_ready), 32'd0);
      tick();
      out_ready = 1'b0;
      chk("after_pop_in_ready", 32'(in_ready), 32'd1);
      chk("after_pop_count", 32'(count), 32'd16);
      chk("after_pop_out", 32'(dout), 32'h41);
      tick();
      in_valid = 1'b0;
      chk("refill_count", 32'(count), 32'd17);
      chk("refill_in_ready", 32'(in_ready), 32'd0);
      drain("full");

      // 40 words with irregular handshakes, wraps pointers twice
      pops0 = n_pop;
      sent = 0;
      cyc = 0;
      while ((sent < 40 || sb.size() != 0 || out_valid) && cyc < 2000) begin
         in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
         din       = 8'(sent);
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("stream_timeout", 32'(cyc < 2000), 32'd1);
      chk("stream_pops", 32'(n_pop - pops0), 32'd40);

      // flush with 5 words held and a write attempted
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; din = 8'(8'h70 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("pre_flush_count", 32'(count), 32'd5);
      flush = 1'b1; in_valid = 1'b1; din = 8'hEE;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_ov", 32'(out_valid), 32'd0);
      in_valid = 1'b1; din = 8'hA5; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_flush_ov0", 32'(out_valid), 32'd0);
      tick();
      chk("post_flush_ov1", 32'(out_valid), 32'd1);
      chk("post_flush_out", 32'(dout), 32'hA5);
      tick();
      chk("post_flush_count", 32'(count), 32'd0);
      out_ready = 1'b0;

      // async reset between edges
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; din = 8'(8'h81 + i);
         tick();
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_af", 32'(almost_full), 32'd0);
      chk("mid_rst_out", 32'(dout), 32'd0);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1; din = 8'h99; out_ready = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("rel_ov0", 32'(out_valid), 32'd0);
      tick();
      chk("rel_ov1", 32'(out_valid), 32'd1);
      chk("rel_out", 32'(dout), 32'h99);
      drain("rel");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
